systolic_tile_sequencer: RTL and testbench

Command-driven sequencer that drives `systolic_array_4x4` for one 4x4 output tile. It accepts a tile command, then:
- reads K packed A-columns and B-rows from the local operand buffers, which have 1-cycle synchronous read latency;
- issues the accumulator-clear pulse, streams the operands, and flushes the skew/propagation pipeline;
- drains the 512-bit result as four 128-bit row beats over a valid/ready stream toward the CFU response path.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/sa_result_drain.sv | 57 +++++
 rtl/systolic_tile_sequencer.sv | 169 ++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and sequencer state encoding for the 4x4 systolic tile datapath.
package tpu_pkg;

    localparam int SA_DIM          = 4;
    localparam int SA_FLUSH_CYCLES = 6;
    localparam int SA_A_W          = 8;
    localparam int SA_B_W          = 9;
    localparam int SA_ACC_W        = 32;

    localparam int SA_A_BUS_W   = SA_DIM * SA_A_W;
    localparam int SA_B_BUS_W   = SA_DIM * SA_B_W;
    localparam int SA_ROW_W     = SA_DIM * SA_ACC_W;
    localparam int SA_C_BUS_W   = SA_DIM * SA_ROW_W;
    localparam int SA_ROW_IDX_W = $clog2(SA_DIM);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_t;

endpackage

// File: rtl/sa_result_drain.sv
// Streams the array result out one 128-bit row per valid/ready handshake.
// The row register is loaded once per tile and held while the consumer stalls.
module sa_result_drain
    import tpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [SA_C_BUS_W-1:0]   i_c_bus,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [SA_ROW_W-1:0]     o_data,
    output logic [SA_ROW_IDX_W-1:0] o_row,
    output logic                    o_last,
    output logic                    o_done
);

    logic                    r_valid;
    logic [SA_ROW_IDX_W-1:0] r_row;
    logic                    w_fire;
    logic                    w_at_last;

    assign w_fire    = r_valid && i_ready;
    assign w_at_last = (r_row == SA_ROW_IDX_W'(SA_DIM - 1));

    // NOTE: state registers use non-blocking assignments and the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_row   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_row   <= '0;
        end else if (w_fire) begin
            if (w_at_last) begin
                r_valid <= 1'b0;
                r_row   <= '0;
            end else begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    // The array holds its results during drain, so the mux output is stable across stalls.
    always_comb begin
        o_data = '0;
        if (r_valid) begin
            o_data = i_c_bus[r_row * SA_ROW_W +: SA_ROW_W];
        end
    end

    assign o_valid = r_valid;
    assign o_row   = r_row;
    assign o_last  = r_valid && w_at_last;
    assign o_done  = w_fire && w_at_last;

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Command-driven sequencer feeding systolic_array_4x4 for one output tile and draining its result.
// Optional busy-cycle counter output perf_cycles when SEQ_PERF_CNT_EN is defined.
module systolic_tile_sequencer
    import tpu_pkg::*;
#(
    parameter int K_W    = 16,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [K_W-1:0]          cmd_k,
    input  logic [ADDR_W-1:0]       cmd_a_base,
    input  logic [ADDR_W-1:0]       cmd_b_base,
    output logic                    a_rd_en,
    output logic [ADDR_W-1:0]       a_rd_addr,
    input  logic [SA_A_BUS_W-1:0]   a_rd_data,
    output logic                    b_rd_en,
    output logic [ADDR_W-1:0]       b_rd_addr,
    input  logic [SA_B_BUS_W-1:0]   b_rd_data,
    output logic                    sa_start,
    output logic                    sa_vld,
    output logic [SA_A_BUS_W-1:0]   sa_a_bus,
    output logic [SA_B_BUS_W-1:0]   sa_b_bus,
    input  logic [SA_C_BUS_W-1:0]   sa_c_bus,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SA_ROW_W-1:0]     res_data,
    output logic [SA_ROW_IDX_W-1:0] res_row,
    output logic                    res_last,
    output logic                    busy
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [K_W-1:0]    r_k;
    logic [K_W-1:0]    r_cnt;
    logic [ADDR_W-1:0] r_a_ptr;
    logic [ADDR_W-1:0] r_b_ptr;

    logic w_accept;
    logic w_rd_en;
    logic w_k_zero;
    logic w_feed_last;
    logic w_flush_last;
    logic w_in_feed;
    logic w_drain_load;
    logic w_drain_done;

    assign w_accept     = cmd_valid && (r_state == ST_IDLE);
    assign w_k_zero     = (r_k == '0);
    assign w_feed_last  = (r_cnt == r_k - 1'b1);
    assign w_flush_last = (r_cnt == K_W'(SA_FLUSH_CYCLES - 1));
    assign w_in_feed    = (r_state == ST_FEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        sa_start    = 1'b0;
        sa_vld      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_nxt = ST_START;
            end
            ST_START: begin
                sa_start    = 1'b1;
                w_rd_en     = !w_k_zero;
                w_state_nxt = w_k_zero ? ST_FLUSH : ST_FEED;
            end
            ST_FEED: begin
                sa_vld  = 1'b1;
                // Read i+1 is issued in FEED cycle i, so the last cycle issues nothing.
                w_rd_en = !w_feed_last;
                if (w_feed_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                sa_vld = 1'b1;
                if (w_flush_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_drain_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read pointers wrap modulo 2^ADDR_W; r_cnt restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_cnt   <= '0;
            r_a_ptr <= '0;
            r_b_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_k     <= cmd_k;
                r_a_ptr <= cmd_a_base;
                r_b_ptr <= cmd_b_base;
            end else if (w_rd_en) begin
                r_a_ptr <= r_a_ptr + 1'b1;
                r_b_ptr <= r_b_ptr + 1'b1;
            end

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_FEED || r_state == ST_FLUSH) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = !cmd_ready;

    assign a_rd_en   = w_rd_en;
    assign b_rd_en   = w_rd_en;
    assign a_rd_addr = w_rd_en ? r_a_ptr : '0;
    assign b_rd_addr = w_rd_en ? r_b_ptr : '0;

    assign sa_a_bus  = w_in_feed ? a_rd_data : '0;
    assign sa_b_bus  = w_in_feed ? b_rd_data : '0;

    // The first DRAIN cycle arms the drain; beats start on the following cycle.
    assign w_drain_load = (r_state == ST_DRAIN) && !res_valid;

    sa_result_drain u_drain (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_drain_load),
        .i_c_bus (sa_c_bus),
        .i_ready (res_ready),
        .o_valid (res_valid),
        .o_data  (res_data),
        .o_row   (res_row),
        .o_last  (res_last),
        .o_done  (w_drain_done)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (busy && (r_perf != '1)) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer with operand buffer and ideal 4x4 array models.
module tb_systolic_tile_sequencer;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [15:0]   cmd_k;
    logic [11:0]   cmd_a_base;
    logic [11:0]   cmd_b_base;
    logic          a_rd_en;
    logic [11:0]   a_rd_addr;
    logic [31:0]   a_rd_data;
    logic          b_rd_en;
    logic [11:0]   b_rd_addr;
    logic [35:0]   b_rd_data;
    logic          sa_start;
    logic          sa_vld;
    logic [31:0]   sa_a_bus;
    logic [35:0]   sa_b_bus;
    logic [511:0]  sa_c_bus;
    logic          res_valid;
    logic          res_ready;
    logic [127:0]  res_data;
    logic [1:0]    res_row;
    logic          res_last;
    logic          busy;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cyc_acc = 0;
    int n_a_rd = 0;
    int n_b_rd = 0;
    int n_vld = 0;
    int n_start = 0;
    int n_res_valid = 0;
    logic [11:0] a_addr_log[$];

    logic [31:0]        a_mem [4096];
    logic [35:0]        b_mem [4096];
    logic signed [31:0] m_c [4][4];

    systolic_tile_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_k      (cmd_k),
        .cmd_a_base (cmd_a_base),
        .cmd_b_base (cmd_b_base),
        .a_rd_en    (a_rd_en),
        .a_rd_addr  (a_rd_addr),
        .a_rd_data  (a_rd_data),
        .b_rd_en    (b_rd_en),
        .b_rd_addr  (b_rd_addr),
        .b_rd_data  (b_rd_data),
        .sa_start   (sa_start),
        .sa_vld     (sa_vld),
        .sa_a_bus   (sa_a_bus),
        .sa_b_bus   (sa_b_bus),
        .sa_c_bus   (sa_c_bus),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_row    (res_row),
        .res_last   (res_last),
        .busy       (busy)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffers with one-cycle synchronous read latency.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    function automatic logic signed [31:0] mul_ab(input logic signed [7:0] a, input logic signed [8:0] b);
        return 32'(a) * 32'(b);
    endfunction

    // Ideal (unskewed) array: clear on sa_start, accumulate outer product on sa_vld.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) m_c[r][c] <= '0;
        end else if (sa_start) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) m_c[r][c] <= '0;
        end else if (sa_vld) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m_c[r][c] <= m_c[r][c] + mul_ab(sa_a_bus[31-8*r -: 8], sa_b_bus[35-9*c -: 9]);
        end
    end

    always_comb begin
        sa_c_bus = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sa_c_bus[128*r + 32*c +: 32] = m_c[r][c];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_rd_en) begin
            n_a_rd <= n_a_rd + 1;
            a_addr_log.push_back(a_rd_addr);
        end
        if (b_rd_en)   n_b_rd <= n_b_rd + 1;
        if (sa_vld)    n_vld <= n_vld + 1;
        if (sa_start)  n_start <= n_start + 1;
        if (res_valid) n_res_valid <= n_res_valid + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [15:0] k, input logic [11:0] ab, input logic [11:0] bb);
        cmd_k      = k;
        cmd_a_base = ab;
        cmd_b_base = bb;
        cmd_valid  = 1'b1;
        check("cmd_ready_before", 128'(cmd_ready), 128'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc_acc   = cyc;
        check("busy_after_accept", 128'(busy), 128'(1));
        check("cmd_ready_busy", 128'(cmd_ready), 128'(0));
    endtask

    task automatic run_drain(input logic [127:0] e0, input logic [127:0] e1,
                             input logic [127:0] e2, input logic [127:0] e3,
                             input int stall_row, input int exp_lat);
        logic [127:0] exp_row [4];
        int waited;
        exp_row = '{e0, e1, e2, e3};
        waited = 0;
        while (!res_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("res_valid_seen", 128'(res_valid), 128'(1));
        check("first_valid_latency", 128'(cyc - cyc_acc), 128'(exp_lat));
        for (int b = 0; b < 4; b++) begin
            check("beat_valid", 128'(res_valid), 128'(1));
            check("beat_row", 128'(res_row), 128'(b));
            check("beat_data", res_data, exp_row[b]);
            check("beat_last", 128'(res_last), 128'(b == 3));
            if (b == stall_row) begin
                res_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", 128'(res_valid), 128'(1));
                    check("stall_row", 128'(res_row), 128'(b));
                    check("stall_data", res_data, exp_row[b]);
                end
                res_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("idle_after_drain", 128'(busy), 128'(0));
        check("no_valid_after_drain", 128'(res_valid), 128'(0));
        check("row_back_to_0", 128'(res_row), 128'(0));
    endtask

    int snap_a, snap_b, snap_vld, snap_start, snap_log, snap_rv;

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_k      = '0;
        cmd_a_base = '0;
        cmd_b_base = '0;
        res_ready  = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end

        // Tile data
        a_mem[12'h010] = 32'h01020304;
        b_mem[12'h020] = {9'd1, 9'd1, 9'd1, 9'd1};
        a_mem[12'hFFE] = 32'h0105090D;
        a_mem[12'hFFF] = 32'h02060A0E;
        a_mem[12'h000] = 32'h03070B0F;
        a_mem[12'h001] = 32'h04080C10;
        b_mem[12'h100] = {9'd1, 9'd0, 9'd0, 9'd0};
        b_mem[12'h101] = {9'd0, 9'd1, 9'd0, 9'd0};
        b_mem[12'h102] = {9'd0, 9'd0, 9'd1, 9'd0};
        b_mem[12'h103] = {9'd0, 9'd0, 9'd0, 9'd1};
        a_mem[12'h200] = 32'h01020304;
        a_mem[12'h201] = 32'h05060708;
        b_mem[12'h300] = {9'd1, 9'd1, 9'd1, 9'd1};
        b_mem[12'h301] = {9'd2, 9'd2, 9'd2, 9'd2};

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_res_valid", 128'(res_valid), 128'(0));
        check("rst_res_row", 128'(res_row), 128'(0));
        check("rst_a_rd_addr", 128'(a_rd_addr), 128'(0));
        check("rst_a_rd_en", 128'(a_rd_en), 128'(0));
        check("rst_sa_start", 128'(sa_start), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // k=1, A={1,2,3,4}, B=all ones
        snap_a = n_a_rd;
        issue(16'd1, 12'h010, 12'h020);
        run_drain({4{32'd1}}, {4{32'd2}}, {4{32'd3}}, {4{32'd4}}, -1, 9);
        check("k1_a_reads", 128'(n_a_rd - snap_a), 128'(1));

        // k=4, A=1..16 with A base wrapping past 0xFFF, B=identity
        snap_a = n_a_rd; snap_b = n_b_rd; snap_vld = n_vld; snap_start = n_start;
        snap_log = a_addr_log.size();
        issue(16'd4, 12'hFFE, 12'h100);
        run_drain(128'h00000004_00000003_00000002_00000001,
                  128'h00000008_00000007_00000006_00000005,
                  128'h0000000C_0000000B_0000000A_00000009,
                  128'h00000010_0000000F_0000000E_0000000D, -1, 12);
        check("k4_a_reads", 128'(n_a_rd - snap_a), 128'(4));
        check("k4_b_reads", 128'(n_b_rd - snap_b), 128'(4));
        check("k4_sa_vld_cycles", 128'(n_vld - snap_vld), 128'(10));
        check("k4_sa_start", 128'(n_start - snap_start), 128'(1));
        check("k4_addr0", 128'(a_addr_log[snap_log + 0]), 128'(12'hFFE));
        check("k4_addr1", 128'(a_addr_log[snap_log + 1]), 128'(12'hFFF));
        check("k4_addr2", 128'(a_addr_log[snap_log + 2]), 128'(12'h000));
        check("k4_addr3", 128'(a_addr_log[snap_log + 3]), 128'(12'h001));

        // k=0: no reads, one start, all-zero result
        snap_a = n_a_rd; snap_b = n_b_rd; snap_vld = n_vld; snap_start = n_start;
        issue(16'd0, 12'h010, 12'h020);
        run_drain('0, '0, '0, '0, -1, 8);
        check("k0_a_reads", 128'(n_a_rd - snap_a), 128'(0));
        check("k0_b_reads", 128'(n_b_rd - snap_b), 128'(0));
        check("k0_sa_start", 128'(n_start - snap_start), 128'(1));
        check("k0_sa_vld_cycles", 128'(n_vld - snap_vld), 128'(6));

        // k=2 with a 3-cycle stall on row 1
        issue(16'd2, 12'h200, 12'h300);
        run_drain({4{32'd11}}, {4{32'd14}}, {4{32'd17}}, {4{32'd20}}, 1, 10);

        // Reset pulsed in the middle of FEED
        issue(16'd8, 12'h400, 12'h400);
        repeat (3) @(negedge clk);
        check("mid_feed_sa_vld", 128'(sa_vld), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_mid_busy", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap_rv = n_res_valid;
        repeat (20) @(negedge clk);
        check("rst_no_partial_beats", 128'(n_res_valid - snap_rv), 128'(0));
        check("rst_idle_again", 128'(cmd_ready), 128'(1));

        // Full run after reset
        issue(16'd1, 12'h010, 12'h020);
        run_drain({4{32'd1}}, {4{32'd2}}, {4{32'd3}}, {4{32'd4}}, -1, 9);
`ifdef SEQ_PERF_CNT_EN
        check("perf_cycles_k1", 128'(perf_cycles), 128'(13));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
